hex_keypad_scanner: RTL and testbench
=====================================

// Module: hex_keypad_scanner
// PURPOSE
//  Input-side counterpart of the board's multiplexed 8-digit hex display.
//  Scans a 4x4 matrix hex keypad, debounces it and emits one 4-bit key code per press.
//  Shifts each accepted code into a 32-bit entry register that feeds the CPU/debug logic.
//  That register can be shown on the display.
// PARAMETERS
//  SCAN_DIV        4096  clk cycles per row-scan tick (>=2); cols sampled on last cycle of a row period
//  DEBOUNCE_TICKS  4     consecutive stable ticks required for press and for release (>=1)
//  REPEAT_TICKS    64    auto-repeat interval in ticks (used only with KEYPAD_REPEAT_EN)
// PORTS
//  clk          in   1   system clock; one clock domain; reset is synchronous and active-high
//  rst          in   1   synchronous active-high reset
//  row_o        out  4   keypad row drive, active-low, one-cold
//  col_i        in   4   keypad column sense, active-low (board pull-ups)
//  value_clr_i  in   1   clears value_o
//  key_valid_o  out  1   single-cycle pulse per accepted key
//  key_code_o   out  4   code of last accepted key = row*4+col, held until next key
//  value_o      out  32  entry register, newest nibble in [3:0]
// BEHAVIOUR
//  Reset: row_o=4'b1110, key_valid_o=0, key_code_o=0, value_o=0, state=SCAN, all counters 0.
//   rst mid-debounce or mid-hold aborts the press. No pulse is emitted.
//  Tick: prescaler counts 0..SCAN_DIV-1. Tick = the cycle at count SCAN_DIV-1. Wraps to 0.
//  FSM states: SCAN, DEBOUNCE, HELD.
//  SCAN:
//   - row r driven low; at each tick sample col_i.
//   - If any col low: latch (r, c=lowest-index low col), set dcnt=1, go DEBOUNCE. Row stays frozen.
//   - Else advance r 0->1->2->3->0.
//  DEBOUNCE:
//   - At each tick, if col c still low: dcnt++.
//   - When dcnt reaches DEBOUNCE_TICKS, the next cycle has key_valid_o=1, key_code_o={r,c}
//     and value_o={value_o[27:0],code}; go HELD.
//   - If col c is high at a tick: drop the candidate, advance r, go SCAN. No pulse.
//   - DEBOUNCE_TICKS=1: pulse the cycle after the detecting tick.
//  HELD:
//   - At each tick, col c high -> rcnt++; col c low -> rcnt=0.
//   - rcnt==DEBOUNCE_TICKS -> go SCAN at next row.
//   - Other keys pressed meanwhile are ignored.
//  Multiple keys in the scanned row: lowest column wins. No n-key rollover.
//  value_clr_i: value_o=0 next cycle. If it coincides with a pulse, clear wins.
//   key_valid_o and key_code_o still update.
//  value_o shifts left by 4; the top nibble is discarded (no saturation).
// CONFIGURATION
//  KEYPAD_REPEAT_EN defined:
//   - In HELD, every REPEAT_TICKS ticks with col c still low, re-emit a pulse and shift the same code in.
//   - Any release tick restarts the repeat counter.
//  KEYPAD_REPEAT_EN undefined: exactly one pulse per press. REPEAT_TICKS is ignored.
// STRUCTURE
//  keypad_pkg:
//   - FSM state enum
//   - ROW_IDLE=4'b1111 and ROW_RESET=4'b1110 constants
//   - code width 4, value width 32
//  Sub-module keypad_tick_gen: SCAN_DIV prescaler producing a 1-cycle tick, synchronous rst.
//  Top holds FSM, row pointer, dcnt/rcnt, repeat counter and entry register.
// TESTING (SCAN_DIV=4, DEBOUNCE_TICKS=3, REPEAT_TICKS=2)
//  1 Reset asserted 2 cycles -> row_o=1110, key_valid_o=0, key_code_o=0, value_o=0.
//  2 Hold row2/col1 low stable -> exactly one pulse, key_code_o=9, value_o=32'h00000009.
//  3 Press row0/col3 for 1 tick then release -> no pulse, FSM back in SCAN, value_o unchanged.
//  4 Enter keys 1..8 in turn, each with release -> value_o=32'h12345678; then key 9 -> 32'h23456789.
//  5 Row1 cols 0 and 3 low together -> code 4.
//    Assert value_clr_i on the pulse cycle -> value_o=0, key_code_o=4.
//  6 Hold key 5 for 3+4 ticks:
//    - with KEYPAD_REPEAT_EN -> 3 pulses, value_o=32'h00000555
//    - without -> 1 pulse, value_o=32'h00000005.

Source files
------------

// File: rtl/keypad_pkg.sv
// ============================================================================
//  Module   : keypad_pkg
//  Brief    : Shared types, constants and helpers for the hex keypad scanner.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package keypad_pkg;

   // Scanner FSM states
   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HELD     = 2'd2
   } state_t;

   // Row drive patterns (active-low, one-cold while scanning)
   localparam logic [3:0] ROW_IDLE  = 4'b1111;
   localparam logic [3:0] ROW_RESET = 4'b1110;

   // Key code and entry register widths
   localparam int CODE_W  = 4;
   localparam int VALUE_W = 32;

   // Active-low drive pattern selecting a single row
   function automatic logic [3:0] row_drive(input logic [1:0] row);
      return ROW_IDLE & ~(4'b0001 << row);
   endfunction

   // Index of the lowest-numbered column pulled low (col is active-low)
   function automatic logic [1:0] lowest_low_col(input logic [3:0] col);
      if (!col[0])      return 2'd0;
      else if (!col[1]) return 2'd1;
      else if (!col[2]) return 2'd2;
      else              return 2'd3;
   endfunction

endpackage : keypad_pkg

`default_nettype wire

// File: rtl/keypad_tick_gen.sv
// ============================================================================
//  Module   : keypad_tick_gen
//  Brief    : Free-running prescaler; o_tick is high for the single cycle in
//             which the count sits at SCAN_DIV-1, then the count wraps to 0.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module keypad_tick_gen #(
   parameter int SCAN_DIV = 4096
) (
   input  logic clk,
   input  logic rst,
   output logic o_tick
);

   localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(SCAN_DIV - 1);

   logic [CW-1:0] r_cnt;

   // Prescaler count 0..SCAN_DIV-1 with wrap
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (r_cnt == C_LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_tick = (r_cnt == C_LAST);

endmodule : keypad_tick_gen

`default_nettype wire

// File: rtl/hex_keypad_scanner.sv
// ============================================================================
//  Module   : hex_keypad_scanner
//  Brief    : 4x4 hex keypad row scanner with debounce, one key code per press
//             and a 32-bit shift-in entry register (newest nibble in [3:0]).
//             Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hex_keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 4096,
   parameter int DEBOUNCE_TICKS = 4,
   parameter int REPEAT_TICKS   = 64
) (
   input  logic                clk,
   input  logic                rst,
   output logic [3:0]          row_o,
   input  logic [3:0]          col_i,
   input  logic                value_clr_i,
   output logic                key_valid_o,
   output logic [CODE_W-1:0]   key_code_o,
   output logic [VALUE_W-1:0]  value_o
);

   // Debounce / release counters must be able to hold DEBOUNCE_TICKS
   localparam int DW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS + 1) : 1;
   localparam logic [DW-1:0] C_DB_LAST = DW'(DEBOUNCE_TICKS - 1);

`ifdef KEYPAD_REPEAT_EN
   localparam int RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS + 1) : 1;
   localparam logic [RW-1:0] C_RPT_LAST = RW'(REPEAT_TICKS - 1);
   logic [RW-1:0] r_rpt;
`else
   // REPEAT_TICKS has no effect without auto-repeat
   logic w_unused_repeat;
   assign w_unused_repeat = (REPEAT_TICKS > 0);
`endif

   state_t              r_state;
   logic [1:0]          r_row;
   logic [1:0]          r_col;
   logic [3:0]          r_row_drv;
   logic [DW-1:0]       r_dcnt;
   logic [DW-1:0]       r_rcnt;
   logic                r_key_valid;
   logic [CODE_W-1:0]   r_key_code;
   logic [VALUE_W-1:0]  r_value;

   logic                w_tick;
   logic                w_any_low;
   logic                w_sel_low;
   logic [1:0]          w_low_col;
   logic [1:0]          w_row_next;
   logic [CODE_W-1:0]   w_scan_code;
   logic [CODE_W-1:0]   w_held_code;

   keypad_tick_gen #(
      .SCAN_DIV (SCAN_DIV)
   ) u_tick_gen (
      .clk    (clk),
      .rst    (rst),
      .o_tick (w_tick)
   );

   assign w_any_low   = ~&col_i;
   assign w_sel_low   = ~col_i[r_col];
   assign w_low_col   = lowest_low_col(col_i);
   assign w_row_next  = r_row + 2'd1;
   assign w_scan_code = {r_row, w_low_col};
   assign w_held_code = {r_row, r_col};

   // Scan / debounce / hold FSM with registered outputs and entry register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_SCAN;
         r_row       <= 2'd0;
         r_col       <= 2'd0;
         r_row_drv   <= ROW_RESET;
         r_dcnt      <= '0;
         r_rcnt      <= '0;
         r_key_valid <= 1'b0;
         r_key_code  <= '0;
         r_value     <= '0;
`ifdef KEYPAD_REPEAT_EN
         r_rpt       <= '0;
`endif
      end else begin
         r_key_valid <= 1'b0;
         if (w_tick) begin
            case (r_state)
               ST_SCAN: begin
                  if (w_any_low) begin
                     // Row stays frozen on the candidate key
                     r_col  <= w_low_col;
                     r_rcnt <= '0;
`ifdef KEYPAD_REPEAT_EN
                     r_rpt  <= '0;
`endif
                     if (DEBOUNCE_TICKS == 1) begin
                        r_key_valid <= 1'b1;
                        r_key_code  <= w_scan_code;
                        r_value     <= {r_value[VALUE_W-CODE_W-1:0], w_scan_code};
                        r_dcnt      <= '0;
                        r_state     <= ST_HELD;
                     end else begin
                        r_dcnt  <= DW'(1);
                        r_state <= ST_DEBOUNCE;
                     end
                  end else begin
                     r_row     <= w_row_next;
                     r_row_drv <= row_drive(w_row_next);
                  end
               end

               ST_DEBOUNCE: begin
                  if (w_sel_low) begin
                     if (r_dcnt == C_DB_LAST) begin
                        r_key_valid <= 1'b1;
                        r_key_code  <= w_held_code;
                        r_value     <= {r_value[VALUE_W-CODE_W-1:0], w_held_code};
                        r_dcnt      <= '0;
                        r_state     <= ST_HELD;
                     end else begin
                        r_dcnt <= r_dcnt + DW'(1);
                     end
                  end else begin
                     // Bounce: drop the candidate and move on
                     r_dcnt    <= '0;
                     r_row     <= w_row_next;
                     r_row_drv <= row_drive(w_row_next);
                     r_state   <= ST_SCAN;
                  end
               end

               ST_HELD: begin
                  if (!w_sel_low) begin
`ifdef KEYPAD_REPEAT_EN
                     r_rpt <= '0;
`endif
                     if (r_rcnt == C_DB_LAST) begin
                        r_rcnt    <= '0;
                        r_row     <= w_row_next;
                        r_row_drv <= row_drive(w_row_next);
                        r_state   <= ST_SCAN;
                     end else begin
                        r_rcnt <= r_rcnt + DW'(1);
                     end
                  end else begin
                     r_rcnt <= '0;
`ifdef KEYPAD_REPEAT_EN
                     if (r_rpt == C_RPT_LAST) begin
                        r_rpt       <= '0;
                        r_key_valid <= 1'b1;
                        r_key_code  <= w_held_code;
                        r_value     <= {r_value[VALUE_W-CODE_W-1:0], w_held_code};
                     end else begin
                        r_rpt <= r_rpt + RW'(1);
                     end
`endif
                  end
               end

               default: begin
                  r_state <= ST_SCAN;
               end
            endcase
         end
         // Clear overrides any shift-in on the same cycle
         if (value_clr_i) begin
            r_value <= '0;
         end
      end
   end

   assign row_o       = r_row_drv;
   assign key_valid_o = r_key_valid;
   assign key_code_o  = r_key_code;
   assign value_o     = r_value;

endmodule : hex_keypad_scanner

`default_nettype wire

// File: tb/tb_hex_keypad_scanner.sv
// ============================================================================
//  Module   : tb_hex_keypad_scanner
//  Brief    : Self-checking bench for hex_keypad_scanner with a 4x4 key matrix
//             model and a scoreboard of expected {code, value} per pulse.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_hex_keypad_scanner;

   localparam int SCAN_DIV       = 4;
   localparam int DEBOUNCE_TICKS = 3;
   localparam int REPEAT_TICKS   = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  row_o;
   logic [3:0]  col_i;
   logic        value_clr_i;
   logic        key_valid_o;
   logic [3:0]  key_code_o;
   logic [31:0] value_o;

   logic [15:0] pressed;
   int          checks = 0;
   int          errors = 0;
   int          pulses = 0;
   logic        prev_valid = 1'b0;

   typedef struct packed {
      logic [3:0]  code;
      logic [31:0] value;
   } exp_t;

   typedef struct {
      logic [3:0]  key;
      logic [31:0] exp_value;
   } vec_t;

   exp_t sb[$];
   exp_t sb_head;
   vec_t tbl[11];

   always #5 clk = ~clk;

   hex_keypad_scanner #(
      .SCAN_DIV       (SCAN_DIV),
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .REPEAT_TICKS   (REPEAT_TICKS)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .row_o       (row_o),
      .col_i       (col_i),
      .value_clr_i (value_clr_i),
      .key_valid_o (key_valid_o),
      .key_code_o  (key_code_o),
      .value_o     (value_o)
   );

   // Key matrix: a pressed key shorts its column to its row when that row is driven low
   always_comb begin
      col_i = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (pressed[r*4+c] && !row_o[r]) col_i[c] = 1'b0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   // Output monitor: every pulse must match the head of the scoreboard
   always @(negedge clk) begin
      if (!rst && key_valid_o) begin
         pulses++;
         chk("pulse_single_cycle", {31'd0, prev_valid}, 32'd0);
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: actual code=%h value=%h, required no pulse",
                     key_code_o, value_o);
         end else begin
            sb_head = sb.pop_front();
            chk("pulse_code", {28'd0, key_code_o}, {28'd0, sb_head.code});
            chk("pulse_value", value_o, sb_head.value);
         end
      end
      prev_valid = key_valid_o;
   end

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Press a key set, wait for the first pulse, hold, release and let release debounce finish
   task automatic press(input logic [15:0] keys, input int hold, input int n_exp);
      int start;
      int n;
      start   = pulses;
      n       = 0;
      pressed = keys;
      while (pulses == start && n < 200) begin
         cycles(1);
         n++;
      end
      if (pulses == start) begin
         checks++;
         errors++;
         $display("FAIL pulse_timeout: actual no pulse in 200 cycles for keys=%h, required a pulse", keys);
      end
      cycles(hold);
      pressed = 16'h0;
      cycles(24);
      chk("pulse_count", pulses - start, n_exp);
      chk("scoreboard_drained", sb.size(), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int start;
      int n;
      logic seen;

      tbl[0]  = '{4'h1, 32'h0000_0091};
      tbl[1]  = '{4'h2, 32'h0000_0912};
      tbl[2]  = '{4'h3, 32'h0000_9123};
      tbl[3]  = '{4'h4, 32'h0009_1234};
      tbl[4]  = '{4'h5, 32'h0091_2345};
      tbl[5]  = '{4'h6, 32'h0912_3456};
      tbl[6]  = '{4'h7, 32'h9123_4567};
      tbl[7]  = '{4'h8, 32'h1234_5678};
      tbl[8]  = '{4'h9, 32'h2345_6789};
      tbl[9]  = '{4'hF, 32'h3456_789F};
      tbl[10] = '{4'h0, 32'h4567_89F0};

      pressed     = 16'h0;
      value_clr_i = 1'b0;
      rst         = 1'b1;

      // Reset state
      cycles(2);
      chk("reset_row", {28'd0, row_o}, 32'h0000_000E);
      chk("reset_valid", {31'd0, key_valid_o}, 32'd0);
      chk("reset_code", {28'd0, key_code_o}, 32'd0);
      chk("reset_value", value_o, 32'd0);
      rst = 1'b0;
      cycles(3);

      // Stable row2/col1 press gives exactly one pulse, code 9
      sb.push_back('{code: 4'h9, value: 32'h0000_0009});
      press(16'h1 << 9, 5, 1);
      chk("key9_code", {28'd0, key_code_o}, 32'h9);
      chk("key9_value", value_o, 32'h0000_0009);

      // One-tick glitch on row0/col3 is rejected
      start = pulses;
      n = 0;
      while (row_o != 4'b1110 && n < 40) begin
         cycles(1);
         n++;
      end
      chk("glitch_row0_seen", {28'd0, row_o}, 32'h0000_000E);
      pressed = 16'h1 << 3;
      cycles(SCAN_DIV);
      pressed = 16'h0;
      cycles(20);
      chk("glitch_no_pulse", pulses - start, 0);
      chk("glitch_value", value_o, 32'h0000_0009);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (row_o == 4'b1011) seen = 1'b1;
         cycles(1);
      end
      chk("glitch_scan_resumed", {31'd0, seen}, 32'd1);

      // Table of single keys, including code 0 and F boundaries
      for (int i = 0; i < 11; i++) begin
         sb.push_back('{code: tbl[i].key, value: tbl[i].exp_value});
         press(16'h1 << tbl[i].key, 0, 1);
         chk("tbl_code_held", {28'd0, key_code_o}, {28'd0, tbl[i].key});
         chk("tbl_value", value_o, tbl[i].exp_value);
      end

      // Clear with no key activity
      start = pulses;
      value_clr_i = 1'b1;
      cycles(1);
      value_clr_i = 1'b0;
      chk("clr_value", value_o, 32'd0);
      chk("clr_code_kept", {28'd0, key_code_o}, 32'h0);
      chk("clr_no_pulse", pulses - start, 0);

      // Re-fill, then row1 cols 0 and 3 together with clear held across the pulse
      sb.push_back('{code: 4'hA, value: 32'h0000_000A});
      press(16'h1 << 10, 0, 1);
      value_clr_i = 1'b1;
      sb.push_back('{code: 4'h4, value: 32'h0000_0000});
      press(16'h0091 & 16'h0090, 0, 1);
      value_clr_i = 1'b0;
      cycles(1);
      chk("multi_code", {28'd0, key_code_o}, 32'h4);
      chk("multi_clr_value", value_o, 32'd0);

      // Long hold of key 5: 3 debounce ticks + 4 held ticks
`ifdef KEYPAD_REPEAT_EN
      sb.push_back('{code: 4'h5, value: 32'h0000_0005});
      sb.push_back('{code: 4'h5, value: 32'h0000_0055});
      sb.push_back('{code: 4'h5, value: 32'h0000_0555});
      press(16'h1 << 5, 16, 3);
      chk("hold_value", value_o, 32'h0000_0555);
`else
      sb.push_back('{code: 4'h5, value: 32'h0000_0005});
      press(16'h1 << 5, 16, 1);
      chk("hold_value", value_o, 32'h0000_0005);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_hex_keypad_scanner

`default_nettype wire
